// File: rtl/pc_sequencer.sv
// Program-counter sequencer: fetch/execute control with branch, halt,
// single-level interrupt/exception entry and return.
module pc_sequencer #(
  parameter logic [29:0] RESET_VEC = 30'h0000_0000,
  parameter logic [29:0] EXC_VEC   = 30'h0000_0020
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imReq,
  output logic [29:0] imAddr,
  input  logic        imReady,
  output logic        instrValid,
  output logic [29:0] pc,
  output logic [29:0] IncPc,
  input  logic        PcSrc,
  input  logic [29:0] tarPc,
  input  logic        stall,
  input  logic        halt,
  input  logic        irq,
  input  logic        eret,
  output logic [29:0] epc,
  output logic        excTaken,
  output logic        halted
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t      r_state;
  logic [29:0] r_pc;
  logic [29:0] r_epc;
  logic        r_int_en;
  logic        r_first;

  state_t      w_state_nxt;
  logic [29:0] w_pc_nxt;
  logic [29:0] w_epc_nxt;
  logic        w_int_en_nxt;
  logic        w_exc;
  logic [29:0] w_inc;

  // Sequential address; the 30-bit width gives the wrap to zero for free.
  assign w_inc = r_pc + 30'd1;

  // Next-state and next-PC selection; priority order inside EXEC matters.
  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_epc_nxt    = r_epc;
    w_int_en_nxt = r_int_en;
    w_exc        = 1'b0;
    case (r_state)
      IDLE: w_state_nxt = FETCH;
      FETCH: begin
        if (imReady) w_state_nxt = EXEC;
      end
      EXEC: begin
        if (!stall) begin
          if (irq && r_int_en) begin
            w_epc_nxt    = w_inc;
            w_pc_nxt     = EXC_VEC;
            w_int_en_nxt = 1'b0;
            w_exc        = 1'b1;
            w_state_nxt  = FETCH;
          end else if (eret) begin
            w_pc_nxt     = r_epc;
            w_int_en_nxt = 1'b1;
            w_state_nxt  = FETCH;
          end else if (halt) begin
            w_pc_nxt    = w_inc;
            w_state_nxt = HALT;
          end else if (PcSrc) begin
            w_pc_nxt    = tarPc;
            w_state_nxt = FETCH;
          end else begin
            w_pc_nxt    = w_inc;
            w_state_nxt = FETCH;
          end
        end
      end
      HALT: begin
        // The PC already points past the halt, so it is the return address.
        if (irq && r_int_en) begin
          w_epc_nxt    = r_pc;
          w_pc_nxt     = EXC_VEC;
          w_int_en_nxt = 1'b0;
          w_exc        = 1'b1;
          w_state_nxt  = FETCH;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State, PC, return address and interrupt-enable registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_pc     <= RESET_VEC;
      r_epc    <= 30'd0;
      r_int_en <= 1'b1;
      r_first  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_state  <= w_state_nxt;
      r_pc     <= w_pc_nxt;
      r_epc    <= w_epc_nxt;
      r_int_en <= w_int_en_nxt;
      // Marks only the first EXEC cycle after a completed fetch.
      r_first  <= (r_state == FETCH) && imReady;
    end
  end

  assign imReq      = (r_state == FETCH);
  assign imAddr     = r_pc;
  assign pc         = r_pc;
  assign IncPc      = w_inc;
  assign epc        = r_epc;
  assign instrValid = r_first;
  assign excTaken   = w_exc;
  assign halted     = (r_state == HALT);

endmodule
